// File: rtl/axi_wr_frame_scheduler.sv
// rtl/axi_wr_frame_scheduler.sv - round-robin AXI write scheduler with per-channel ping-pong frame buffers
// Optional macro WR_PRIO_CH_EN: channel PRIO_CH wins arbitration whenever it requests.
module axi_wr_frame_scheduler #(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         MEM_DQ_WIDTH    = 32,
  parameter int         NUM_CH          = 5,
  parameter logic [3:0] BURST_LEN       = 4'd15,
  parameter int         ADDR_STEP       = 128,
  parameter int         CH_SHIFT        = 23,
`ifdef WR_PRIO_CH_EN
  parameter int         PRIO_CH         = 4,
`endif
  parameter int         BUF_SHIFT       = 22
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_vsync,
  input  logic [NUM_CH-1:0]                ch_rready,
  output logic [NUM_CH-1:0]                ch_rd_en,
  input  logic [NUM_CH*MEM_DQ_WIDTH*8-1:0] ch_data,
  output logic [CTRL_ADDR_WIDTH-1:0]       axi_awaddr,
  output logic [3:0]                       axi_awid,
  output logic [3:0]                       axi_awlen,
  output logic [2:0]                       axi_awsize,
  output logic [1:0]                       axi_awburst,
  output logic                             axi_awvalid,
  input  logic                             axi_awready,
  output logic [MEM_DQ_WIDTH*8-1:0]        axi_wdata,
  output logic [MEM_DQ_WIDTH-1:0]          axi_wstrb,
  output logic                             axi_wvalid,
  input  logic                             axi_wready,
  input  logic                             axi_wlast,
  output logic [NUM_CH-1:0]                rd_frame_sel,
  output logic                             init_done
);

  localparam int DW = MEM_DQ_WIDTH * 8;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_W, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              grant_q, grant_d;
  logic [CW-1:0]              rr_q, rr_d;
  logic [3:0]                 beat_q, beat_d;
  logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic [NUM_CH-1:0]          wr_buf_q, wr_buf_d;
  logic [NUM_CH-1:0]          rd_sel_q, rd_sel_d;
  logic [NUM_CH-1:0]          pending_q, pending_d;
  logic [NUM_CH-1:0]          done_seen_q, done_seen_d;
  logic                       init_done_q, init_done_d;
  logic [BUF_SHIFT-1:0]       offset_q [NUM_CH];
  logic [BUF_SHIFT-1:0]       offset_d [NUM_CH];
  logic [NUM_CH-1:0]          vs_meta_q, vs_meta_d;
  logic [NUM_CH-1:0]          vs_sync_q, vs_sync_d;
  logic [NUM_CH-1:0]          vs_prev_q, vs_prev_d;

  logic              arb_found;
  logic [CW-1:0]     arb_sel;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] vs_edge;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] flip;

  // First requester at or after the rr pointer, wrapping past the last channel.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = rr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!arb_found && ch_rready[(int'(rr_q) + i) % NUM_CH]) begin
        arb_found = 1'b1;
        arb_sel   = CW'((int'(rr_q) + i) % NUM_CH);
      end
    end
`ifdef WR_PRIO_CH_EN
    if (ch_rready[PRIO_CH]) begin
      arb_found = 1'b1;
      arb_sel   = CW'(PRIO_CH);
    end
`endif
  end

  // A channel's buffer may not flip while its burst address is being formed or used.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      busy[k] = ((state_q == S_ARB) && arb_found && (arb_sel == CW'(k))) ||
                (((state_q == S_AW) || (state_q == S_W)) && (grant_q == CW'(k)));
    end
  end

  assign vs_edge = vs_sync_q & ~vs_prev_q;
  assign pend    = pending_q | vs_edge;
  assign flip    = pend & ~busy;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    beat_d      = beat_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    offset_d    = offset_q;
    vs_meta_d   = ch_vsync;
    vs_sync_d   = vs_meta_q;
    vs_prev_d   = vs_sync_q;

    case (state_q)
      S_IDLE: begin
        if (|ch_rready) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          grant_d   = arb_sel;
          awaddr_d  = (CTRL_ADDR_WIDTH'(arb_sel) << CH_SHIFT) |
                      (CTRL_ADDR_WIDTH'(wr_buf_q[arb_sel]) << BUF_SHIFT) |
                      CTRL_ADDR_WIDTH'(offset_q[arb_sel]);
          awvalid_d = 1'b1;
          state_d   = S_AW;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AW: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = 4'd0;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (axi_wready) begin
          beat_d = beat_q + 4'd1;
          if (axi_wlast || (beat_q == BURST_LEN)) begin
            wvalid_d = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        offset_d[grant_q] = offset_q[grant_q] + BUF_SHIFT'(ADDR_STEP);
`ifdef WR_PRIO_CH_EN
        if (grant_q != CW'(PRIO_CH))
          rr_d = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
`else
        rr_d = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flip overrides the DONE offset increment so a new frame starts at offset 0.
    for (int k = 0; k < NUM_CH; k++) begin
      if (flip[k]) offset_d[k] = '0;
    end
    pending_d   = pend & ~flip;
    rd_sel_d    = (rd_sel_q & ~flip) | (wr_buf_q & flip);
    wr_buf_d    = wr_buf_q ^ flip;
    done_seen_d = done_seen_q | flip;
    init_done_d = init_done_q | (&done_seen_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      beat_q      <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wr_buf_q    <= '0;
      rd_sel_q    <= '0;
      pending_q   <= '0;
      done_seen_q <= '0;
      init_done_q <= 1'b0;
      vs_meta_q   <= '0;
      vs_sync_q   <= '0;
      vs_prev_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) offset_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      beat_q      <= beat_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wr_buf_q    <= wr_buf_d;
      rd_sel_q    <= rd_sel_d;
      pending_q   <= pending_d;
      done_seen_q <= done_seen_d;
      init_done_q <= init_done_d;
      vs_meta_q   <= vs_meta_d;
      vs_sync_q   <= vs_sync_d;
      vs_prev_q   <= vs_prev_d;
      for (int k = 0; k < NUM_CH; k++) offset_q[k] <= offset_d[k];
    end
  end

  // FWFT data: the granted FIFO head is presented directly, popped on each accepted beat.
  always_comb begin
    axi_wdata = '0;
    ch_rd_en  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wvalid_q && (grant_q == CW'(k))) begin
        axi_wdata   = ch_data[k*DW +: DW];
        ch_rd_en[k] = axi_wready;
      end
    end
  end

  assign axi_awaddr   = awaddr_q;
  assign axi_awid     = 4'(grant_q);
  assign axi_awlen    = BURST_LEN;
  assign axi_awsize   = 3'b101;
  assign axi_awburst  = 2'b01;
  assign axi_awvalid  = awvalid_q;
  assign axi_wstrb    = '1;
  assign axi_wvalid   = wvalid_q;
  assign rd_frame_sel = rd_sel_q;
  assign init_done    = init_done_q;

endmodule
